// File: rtl/riscv_pipe_pkg.sv
// Shared types and constants for the RV32 pipeline back-end registers.
package riscv_pipe_pkg;

  localparam int unsigned XLEN_DEF = 32;
  localparam logic [4:0]  REG_X0   = 5'd0;

  typedef enum logic {
    MEM_IDLE = 1'b0,
    MEM_WAIT = 1'b1
  } mem_state_t;

endpackage

// File: rtl/dmem_access_fsm.sv
// Data-memory access control: request/write-enable decode, stall generation
// and IDLE/WAIT tracking of an outstanding access.
module dmem_access_fsm
  import riscv_pipe_pkg::*;
(
  input  logic clk,
  input  logic rst_n,
  input  logic mem_read_i,
  input  logic mem_write_i,
  input  logic dmem_ready_i,
  output logic dmem_req_o,
  output logic dmem_we_o,
  output logic mem_stall_o
);

  mem_state_t state_q, state_d;
  logic       mem_op;

  // State register, synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= MEM_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next state and handshake outputs; a same-cycle ready never enters WAIT.
  always_comb begin
    mem_op      = mem_read_i | mem_write_i;
    dmem_req_o  = mem_op;
    dmem_we_o   = mem_write_i;
    mem_stall_o = mem_op & ~dmem_ready_i;
    state_d     = state_q;
    case (state_q)
      MEM_IDLE: if (mem_op && !dmem_ready_i) state_d = MEM_WAIT;
      MEM_WAIT: if (dmem_ready_i)            state_d = MEM_IDLE;
      default:                               state_d = MEM_IDLE;
    endcase
  end

endmodule

// File: rtl/ex_mem_wb_pipe.sv
// EX/MEM and MEM/WB pipeline registers with data-memory access control.
// Optional stall-cycle performance counter enabled by `define PIPE_PERF_CNT_EN.
module ex_mem_wb_pipe
  import riscv_pipe_pkg::*;
#(
  parameter int unsigned XLEN = XLEN_DEF
`ifdef PIPE_PERF_CNT_EN
  ,
  parameter int unsigned CNT_W = 32
`endif
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            ex_RegWrite,
  input  logic            ex_MemRead,
  input  logic            ex_MemWrite,
  input  logic            ex_MemtoReg,
  input  logic [XLEN-1:0] ex_alu_result,
  input  logic [XLEN-1:0] ex_rs2_data,
  input  logic [4:0]      ex_Rd,
  input  logic            ex_flush,
  output logic            dmem_req,
  output logic            dmem_we,
  output logic [XLEN-1:0] dmem_addr,
  output logic [XLEN-1:0] dmem_wdata,
  input  logic            dmem_ready,
  input  logic [XLEN-1:0] dmem_rdata,
  output logic            EX_MEM_RegWrite,
  output logic [4:0]      EX_MEM_Rd,
  output logic [XLEN-1:0] EX_MEM_alu_result,
  output logic            MEM_WB_RegWr,
  output logic [4:0]      MEM_WB_Rd,
  output logic [XLEN-1:0] MEM_WB_wdata,
  output logic            mem_stall
`ifdef PIPE_PERF_CNT_EN
  ,
  output logic [CNT_W-1:0] stall_cycles
`endif
);

  logic            ex_mem_regwrite_q, ex_mem_regwrite_d;
  logic            ex_mem_memread_q,  ex_mem_memread_d;
  logic            ex_mem_memwrite_q, ex_mem_memwrite_d;
  logic            ex_mem_memtoreg_q, ex_mem_memtoreg_d;
  logic [XLEN-1:0] ex_mem_alu_q,      ex_mem_alu_d;
  logic [XLEN-1:0] ex_mem_rs2_q,      ex_mem_rs2_d;
  logic [4:0]      ex_mem_rd_q,       ex_mem_rd_d;

  logic            mem_wb_regwr_q,    mem_wb_regwr_d;
  logic [4:0]      mem_wb_rd_q,       mem_wb_rd_d;
  logic [XLEN-1:0] mem_wb_wdata_q,    mem_wb_wdata_d;

  dmem_access_fsm u_dmem_fsm (
    .clk          (clk),
    .rst_n        (rst_n),
    .mem_read_i   (ex_mem_memread_q),
    .mem_write_i  (ex_mem_memwrite_q),
    .dmem_ready_i (dmem_ready),
    .dmem_req_o   (dmem_req),
    .dmem_we_o    (dmem_we),
    .mem_stall_o  (mem_stall)
  );

  // Next-state for both pipeline registers; everything holds while stalled.
  always_comb begin
    ex_mem_regwrite_d = ex_mem_regwrite_q;
    ex_mem_memread_d  = ex_mem_memread_q;
    ex_mem_memwrite_d = ex_mem_memwrite_q;
    ex_mem_memtoreg_d = ex_mem_memtoreg_q;
    ex_mem_alu_d      = ex_mem_alu_q;
    ex_mem_rs2_d      = ex_mem_rs2_q;
    ex_mem_rd_d       = ex_mem_rd_q;
    mem_wb_regwr_d    = mem_wb_regwr_q;
    mem_wb_rd_d       = mem_wb_rd_q;
    mem_wb_wdata_d    = mem_wb_wdata_q;
    if (!mem_stall) begin
      // A flush turns the incoming instruction into a bubble; data fields still load.
      ex_mem_regwrite_d = ex_RegWrite & ~ex_flush;
      ex_mem_memread_d  = ex_MemRead  & ~ex_flush;
      ex_mem_memwrite_d = ex_MemWrite & ~ex_flush;
      ex_mem_memtoreg_d = ex_MemtoReg & ~ex_flush;
      ex_mem_alu_d      = ex_alu_result;
      ex_mem_rs2_d      = ex_rs2_data;
      ex_mem_rd_d       = ex_flush ? REG_X0 : ex_Rd;
      mem_wb_regwr_d    = ex_mem_regwrite_q;
      mem_wb_rd_d       = ex_mem_rd_q;
      mem_wb_wdata_d    = ex_mem_memtoreg_q ? dmem_rdata : ex_mem_alu_q;
    end
  end

  // Pipeline register update with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      ex_mem_regwrite_q <= 1'b0;
      ex_mem_memread_q  <= 1'b0;
      ex_mem_memwrite_q <= 1'b0;
      ex_mem_memtoreg_q <= 1'b0;
      ex_mem_alu_q      <= '0;
      ex_mem_rs2_q      <= '0;
      ex_mem_rd_q       <= '0;
      mem_wb_regwr_q    <= 1'b0;
      mem_wb_rd_q       <= '0;
      mem_wb_wdata_q    <= '0;
    end else begin
      ex_mem_regwrite_q <= ex_mem_regwrite_d;
      ex_mem_memread_q  <= ex_mem_memread_d;
      ex_mem_memwrite_q <= ex_mem_memwrite_d;
      ex_mem_memtoreg_q <= ex_mem_memtoreg_d;
      ex_mem_alu_q      <= ex_mem_alu_d;
      ex_mem_rs2_q      <= ex_mem_rs2_d;
      ex_mem_rd_q       <= ex_mem_rd_d;
      mem_wb_regwr_q    <= mem_wb_regwr_d;
      mem_wb_rd_q       <= mem_wb_rd_d;
      mem_wb_wdata_q    <= mem_wb_wdata_d;
    end
  end

  assign dmem_addr         = ex_mem_alu_q;
  assign dmem_wdata        = ex_mem_rs2_q;
  assign EX_MEM_RegWrite   = ex_mem_regwrite_q;
  assign EX_MEM_Rd         = ex_mem_rd_q;
  assign EX_MEM_alu_result = ex_mem_alu_q;
  assign MEM_WB_RegWr      = mem_wb_regwr_q;
  assign MEM_WB_Rd         = mem_wb_rd_q;
  assign MEM_WB_wdata      = mem_wb_wdata_q;

`ifdef PIPE_PERF_CNT_EN
  logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;

  // Saturating count of stalled cycles.
  always_comb begin
    stall_cnt_d = stall_cnt_q;
    if (mem_stall && (stall_cnt_q != '1)) begin
      stall_cnt_d = stall_cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
    end
  end

  // Counter register with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      stall_cnt_q <= '0;
    end else begin
      stall_cnt_q <= stall_cnt_d;
    end
  end

  assign stall_cycles = stall_cnt_q;
`endif

endmodule
